bus_timer_responder: RTL

BUS_TIMER_RESPONDER -- requirements
Module: bus_timer_responder

---
 rtl/timer_regs_pkg.sv | 31 +++
 rtl/bus_timer_responder_core.sv | 109 ++++++++++
 rtl/bus_timer_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/timer_regs_pkg.sv
// Shared register map, CTRL bit positions and bus FSM states
// for the bus timer responder and its timer core.
package timer_regs_pkg;

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_LOAD   = 32'h04;
   localparam logic [31:0] A_COUNT  = 32'h08;
   localparam logic [31:0] A_STATUS = 32'h0C;
   localparam logic [31:0] A_PRESC  = 32'h10;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_W      = 3;

   localparam int STATUS_EXPIRED = 0;
   localparam int PRESC_W        = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic ctrl;
      logic load;
      logic status;
   } wr_strb_t;

endpackage

// File: rtl/bus_timer_responder_core.sv
// Timer core: CTRL/LOAD/COUNT/STATUS state, tick generation and expiry.
// The PRESCALE divider exists only when TIMER_PRESCALER_EN is defined.
module timer_core
   import timer_regs_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  wr_strb_t          wr_i,
`ifdef TIMER_PRESCALER_EN
   input  logic              wr_presc_i,
   output logic [PRESC_W-1:0] presc_o,
`endif
   input  logic [DATA_W-1:0] wdata_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] load_o,
   output logic [DATA_W-1:0] count_o,
   output logic              expired_o,
   output logic              irq_o
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic              exp_q, exp_d;
   logic              irq_q, irq_d;
   logic              tick;
   logic              expire;

`ifdef TIMER_PRESCALER_EN
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] div_q, div_d;

   always_comb begin
      presc_d = presc_q;
      div_d   = div_q + 8'd1;
      tick    = 1'b0;
      if (div_q == presc_q) begin
         tick  = 1'b1;
         div_d = '0;
      end
      if (wr_presc_i) presc_d = wdata_i[PRESC_W-1:0];
      if (wr_presc_i || wr_i.ctrl) div_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         div_q   <= '0;
      end else begin
         presc_q <= presc_d;
         div_q   <= div_d;
      end
   end

   assign presc_o = presc_q;
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      exp_d   = exp_q;
      irq_d   = exp_q & ctrl_q[CTRL_IRQ_EN];
      expire  = tick & ctrl_q[CTRL_EN] & (count_q == '0);

      if (tick && ctrl_q[CTRL_EN]) begin
         if (count_q != '0) count_d = count_q - DATA_W'(1);
         else if (ctrl_q[CTRL_RELOAD]) count_d = load_q;
         else ctrl_d[CTRL_EN] = 1'b0;
      end

      if (wr_i.ctrl) ctrl_d = wdata_i[CTRL_W-1:0];
      // LOAD writes override any same-cycle decrement or reload
      if (wr_i.load) begin
         load_d  = wdata_i;
         count_d = wdata_i;
      end

      if (wr_i.status && wdata_i[STATUS_EXPIRED]) exp_d = 1'b0;
      if (expire) exp_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= '0;
         load_q  <= '0;
         count_q <= '0;
         exp_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         load_q  <= load_d;
         count_q <= count_d;
         exp_q   <= exp_d;
         irq_q   <= irq_d;
      end
   end

   assign ctrl_o    = ctrl_q;
   assign load_o    = load_q;
   assign count_o   = count_q;
   assign expired_o = exp_q;
   assign irq_o     = irq_q;

endmodule

// File: rtl/bus_timer_responder.sv
// Bus responder: IDLE/ACCESS/RESP transfer FSM and register decode.
// Optional PRESCALE register at 0x10 when TIMER_PRESCALER_EN is defined.
module bus_timer_responder
   import timer_regs_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              irq
);

   state_e            state_q, state_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       a32;
   logic              hit_ctrl, hit_load, hit_count;
   logic              hit_status, hit_presc;
   logic              legal;
   logic [DATA_W-1:0] rd_val;
   wr_strb_t          strb;

   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] load;
   logic [DATA_W-1:0] count;
   logic              expired;

`ifdef TIMER_PRESCALER_EN
   logic               wr_presc;
   logic [PRESC_W-1:0] presc;
`endif

   assign a32        = 32'(addr_q);
   assign hit_ctrl   = (a32 == A_CTRL);
   assign hit_load   = (a32 == A_LOAD);
   assign hit_count  = (a32 == A_COUNT);
   assign hit_status = (a32 == A_STATUS);
`ifdef TIMER_PRESCALER_EN
   assign hit_presc  = (a32 == A_PRESC);
`else
   assign hit_presc  = 1'b0;
`endif

   // Misaligned addresses never match an aligned register constant
   assign legal = hit_ctrl | hit_load | hit_status | hit_presc
                | (hit_count & ~wr_q);

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         hit_ctrl:   rd_val = DATA_W'(ctrl);
         hit_load:   rd_val = load;
         hit_count:  rd_val = count;
         hit_status: rd_val = DATA_W'(expired);
`ifdef TIMER_PRESCALER_EN
         hit_presc:  rd_val = DATA_W'(presc);
`endif
         default:    rd_val = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      strb    = '0;
`ifdef TIMER_PRESCALER_EN
      wr_presc = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               wr_d    = wr;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            err_d   = ~legal;
            rdata_d = (legal && !wr_q) ? rd_val : '0;
            if (legal && wr_q) begin
               strb.ctrl   = hit_ctrl;
               strb.load   = hit_load;
               strb.status = hit_status;
`ifdef TIMER_PRESCALER_EN
               wr_presc    = hit_presc;
`endif
            end
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign ready = (state_q == ST_RESP);
   assign rdata = ready ? rdata_q : '0;
   assign err   = ready & err_q;

   timer_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (strb),
`ifdef TIMER_PRESCALER_EN
      .wr_presc_i (wr_presc),
      .presc_o    (presc),
`endif
      .wdata_i    (wdata_q),
      .ctrl_o     (ctrl),
      .load_o     (load),
      .count_o    (count),
      .expired_o  (expired),
      .irq_o      (irq)
   );

endmodule
